// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream, assembles 19-bit words into instruction memory,
// then releases the CPU after a fixed idle delay.
module program_loader #(
  parameter int RUN_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [18:0] imem_wdata,
  output logic        cpu_run,
  output logic [8:0]  words_loaded,
  output logic [18:0] checksum
);
  typedef enum logic [2:0] {S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_WAIT, S_DONE} state_t;
  state_t state, nextState;
  logic        xfer;
  logic [8:0]  lenN;
  logic [2:0]  byte0;
  logic [7:0]  byte1;
  logic [3:0]  waitCnt;
  logic [18:0] word;
  assign xfer = in_valid && in_ready;
  assign word = {byte0, byte1, in_data};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_LEN;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      S_LEN:   nextState = xfer ? S_B0 : S_LEN;
      S_B0:    nextState = xfer ? S_B1 : S_B0;
      S_B1:    nextState = xfer ? S_B2 : S_B1;
      S_B2:    nextState = xfer ? S_WRITE : S_B2;
      S_WRITE: nextState = (words_loaded == lenN) ? S_WAIT : S_B0;
      S_WAIT:  nextState = (waitCnt == 4'(RUN_DELAY - 1)) ? S_DONE : S_WAIT;
      S_DONE:  nextState = start ? S_LEN : S_DONE;
      default: nextState = S_LEN;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= 8'd0;
      imem_wdata   <= 19'd0;
      cpu_run      <= 1'b0;
      words_loaded <= 9'd0;
      checksum     <= 19'd0;
      lenN         <= 9'd0;
      byte0        <= 3'd0;
      byte1        <= 8'd0;
      waitCnt      <= 4'd0;
    end else begin
      in_ready <= nextState inside {S_LEN, S_B0, S_B1, S_B2};
      imem_we  <= nextState == S_WRITE;
      cpu_run  <= nextState == S_DONE;
      waitCnt  <= (state == S_WAIT) ? waitCnt + 4'd1 : 4'd0;
      if (xfer && state == S_LEN) begin
        lenN         <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        imem_addr    <= 8'd0;
        words_loaded <= 9'd0;
        checksum     <= 19'd0;
      end
      if (xfer && state == S_B0) byte0 <= in_data[2:0];
      if (xfer && state == S_B1) byte1 <= in_data;
      if (xfer && state == S_B2) begin
        imem_wdata   <= word;
        checksum     <= checksum ^ word;
        words_loaded <= words_loaded + 9'd1;
      end
      if (state == S_WRITE) imem_addr <= imem_addr + 8'd1;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed loads checked against a queue-based model of the load protocol.
module tb_program_loader;
  localparam int RD = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        start = 1'b0;
  logic        imemWe;
  logic [7:0]  imemAddr;
  logic [18:0] imemWdata;
  logic        cpuRun;
  logic [8:0]  wordsLoaded;
  logic [18:0] checksum;
  int total = 0;
  int bad = 0;
  logic [7:0]  payload[$];
  logic [7:0]  wrA[$];
  logic [18:0] wrD[$];
  int cyc = 0, lastWe = 0, runRise = 0, weDouble = 0, weRun = 0;
  logic prevWe = 1'b0, prevRun = 1'b0;

  program_loader #(.RUN_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .start(start), .imem_we(imemWe), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .cpu_run(cpuRun), .words_loaded(wordsLoaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (imemWe) begin
      wrA.push_back(imemAddr);
      wrD.push_back(imemWdata);
      lastWe = cyc;
      if (prevWe) weDouble++;
      if (cpuRun) weRun++;
    end
    if (cpuRun && !prevRun) runRise = cyc;
    prevWe = imemWe;
    prevRun = cpuRun;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, input bit noise);
    int k;
    repeat (gap) begin
      @(negedge clk);
      inValid = 1'b0;
      start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    @(negedge clk);
    inValid = 1'b1;
    inData = b;
    start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    k = 0;
    while (!inReady && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", k, 0);
  endtask

  task automatic runLoad(input logic [7:0] lenByte, input int minGap, input int maxGap,
                         input bit noise, input bit early);
    int n, k;
    int expD[$];
    int cs;
    wrA.delete();
    wrD.delete();
    n = (lenByte == 8'd0) ? 256 : int'(lenByte);
    sendByte(lenByte, 0, noise);
    for (int i = 0; i < payload.size(); i++) begin
      if (early && i == payload.size() - 1) begin
        @(negedge clk);
        inValid = 1'b0;
        chk("no_early_we", wrA.size(), 0);
      end
      sendByte(payload[i], $urandom_range(maxGap, minGap), noise);
    end
    @(negedge clk);
    inValid = 1'b0;
    start = 1'b0;
    k = 0;
    while (!cpuRun && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cpu_run_up", cpuRun, 1);
    @(negedge clk);
    cs = 0;
    for (int w = 0; w < n; w++) begin
      expD.push_back((int'(payload[3*w]) % 8) * 65536 + int'(payload[3*w+1]) * 256 + int'(payload[3*w+2]));
      cs = cs ^ expD[w];
    end
    chk("write_count", wrA.size(), n);
    for (int w = 0; w < n && w < wrA.size(); w++) begin
      chk($sformatf("wr_addr%0d", w), wrA[w], w % 256);
      chk($sformatf("wr_data%0d", w), wrD[w], expD[w]);
    end
    chk("words_loaded", wordsLoaded, n);
    chk("checksum", checksum, cs);
    chk("run_delay", runRise - lastWe, RD + 1);
    chk("we_back_to_back", weDouble, 0);
    chk("we_with_run", weRun, 0);
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_in_ready"}, inReady, 0);
    chk({tag, "_imem_we"}, imemWe, 0);
    chk({tag, "_imem_addr"}, imemAddr, 0);
    chk({tag, "_imem_wdata"}, imemWdata, 0);
    chk({tag, "_cpu_run"}, cpuRun, 0);
    chk({tag, "_words_loaded"}, wordsLoaded, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  initial begin
    int n;
    logic [8:0] heldWords;
    inValid = 1'b1;
    inData = 8'hA5;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst = 1'b1;
    inValid = 1'b0;
    #1;
    chk("ready_before_edge", inReady, 0);
    @(negedge clk);
    chk("ready_after_edge", inReady, 1);

    payload = '{8'h05, 8'hAB, 8'hCD, 8'h02, 8'h34, 8'h56};
    runLoad(8'h02, 0, 0, 1'b0, 1'b0);
    chk("fixed_checksum", checksum, 19'h79F9B);
    chk("fixed_word0", wrD.size() > 0 ? wrD[0] : 19'h0, 19'h5ABCD);

    inValid = 1'b1;
    inData = 8'h01;
    repeat (5) @(negedge clk);
    chk("done_holds_run", cpuRun, 1);
    chk("done_not_ready", inReady, 0);
    chk("done_no_write", wrA.size(), 2);
    inValid = 1'b0;

    heldWords = wordsLoaded;
    @(negedge clk);
    start = 1'b1;
    inValid = 1'b1;
    inData = 8'h05;
    @(negedge clk);
    start = 1'b0;
    inValid = 1'b0;
    chk("start_clears_run", cpuRun, 0);
    chk("start_ready", inReady, 1);
    chk("start_holds_words", wordsLoaded, heldWords);
    chk("start_holds_cs", checksum, 19'h79F9B);
    payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
    runLoad(8'h01, 0, 1, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    payload = '{8'hFF, 8'h00, 8'h00};
    runLoad(8'h01, 3, 3, 1'b0, 1'b1);
    chk("upper_bits_dropped", wrD.size() > 0 ? wrD[0] : 19'h0, 19'h70000);

    repeat (4) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = $urandom_range(20, 1);
      payload.delete();
      repeat (3 * n) payload.push_back(8'($urandom));
      runLoad(8'(n), 0, 2, 1'b1, 1'b0);
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    payload.delete();
    repeat (768) payload.push_back(8'($urandom));
    runLoad(8'h00, 0, 1, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sendByte(8'h03, 0, 1'b0);
    repeat (8) sendByte(8'($urandom), 0, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    chk("mid_load_words", wordsLoaded, 2);
    #2;
    rst = 1'b0;
    inValid = 1'b1;
    inData = 8'h77;
    #1;
    checkZero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", inReady, 1);
    payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
    runLoad(8'h01, 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: RUN_DELAY, default 2, number of idle cycles between the final instruction-memory write and cpu_run assertion; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  8  byte stream from the host link.
REQ-005 Port: in_valid  input  1  in_data is valid this cycle.
REQ-006 Port: in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready at the clock edge.
REQ-007 Port: start  input  1  single-cycle reload request.
REQ-008 Port: imem_we  output  1  instruction-memory write strobe.
REQ-009 Port: imem_addr  output  8  instruction-memory write address.
REQ-010 Port: imem_wdata  output  19  instruction word to write.
REQ-011 Port: cpu_run  output  1  releases the 19-bit pipelined CPU; the CPU is held in reset while this is 0.
REQ-012 Port: words_loaded  output  9  count of words written in the current load.
REQ-013 Port: checksum  output  19  running XOR of all words written in the current load.

Function
REQ-014 States: S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_WAIT, S_DONE.
REQ-015 All outputs are registered; in_ready is 1 exactly when the state is S_LEN, S_B0, S_B1 or S_B2.
REQ-016 S_LEN: the accepted byte is the word count N (0x00 means 256, otherwise 1..255); latch N, clear the address, words_loaded and checksum, then go to S_B0.
REQ-017 S_B0: accept a byte; bits [2:0] become word[18:16] and bits [7:3] are ignored; go to S_B1.
REQ-018 S_B1: the accepted byte becomes word[15:8]; go to S_B2.
REQ-019 S_B2: the accepted byte becomes word[7:0]; go to S_WRITE.
REQ-020 In any receive state, a cycle without a transfer holds the state and all partial bytes.
REQ-021 S_WRITE lasts exactly one cycle: imem_we=1 with imem_addr = current address and imem_wdata = the assembled word. In the same cycle, checksum ^= word and words_loaded += 1.
REQ-022 Write latency: imem_we is high in the cycle immediately after the edge that accepted byte 2.
REQ-023 Leaving S_WRITE: the address increments (8-bit, wrapping 255→0). If words_loaded reaches N, go to S_WAIT; otherwise go to S_B0.
REQ-024 With N=256, the final write is to address 255; the address wraps to 0 and no further write occurs.
REQ-025 S_WAIT: count RUN_DELAY cycles with imem_we=0, then go to S_DONE.
REQ-026 S_DONE: cpu_run=1 and in_ready=0; in_data and in_valid are ignored.
REQ-027 start is honoured only in S_DONE. It clears cpu_run on the next edge and moves to S_LEN; words_loaded and checksum hold until the next length byte is accepted.
REQ-028 start asserted in any other state is ignored. start and in_valid arriving together in S_DONE: start wins and the byte is not accepted.
REQ-029 imem_we is never high in two consecutive cycles; imem_we and cpu_run are never high together.

Reset
REQ-030 rst low asynchronously forces state S_LEN, and sets in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, words_loaded=0, checksum=0. This holds regardless of state, including mid-word or mid-S_WAIT.
REQ-031 On the first edge after rst rises, in_ready becomes 1. Bytes presented while rst is low are discarded, and any partial word is lost.

Verification
REQ-032 Len 0x02, then bytes 05 AB CD 02 34 56 -> writes addr0=0x5ABCD and addr1=0x23456; words_loaded=2; checksum=0x79F9B; cpu_run rises RUN_DELAY+1 cycles after the second imem_we.
REQ-033 Len 0x00 followed by 768 bytes -> 256 writes at addresses 0..255 in order; words_loaded=256; no write after address 255; cpu_run=1.
REQ-034 Len 0x01, bytes FF 00 00 with in_valid deasserted for 3 cycles between each byte -> a single write of 0x70000 (upper bits of byte 0 dropped); no early imem_we.
REQ-035 Len 0x03, rst pulsed low after byte 1 of word 2 -> outputs zero immediately; after release, the next byte is treated as a length byte.
REQ-036 In S_DONE, pulse start with in_valid=1 -> cpu_run=0 next cycle, byte not consumed; a new len 0x01 plus 3 bytes reloads addr0 and cpu_run re-asserts.
